// File: rtl/shared_debounce_scheduler.sv
// Time-shared key debouncer: a scan FSM visits one channel per cycle after each
// divider tick, filters it through a shared counter datapath and queues edge events.
module shared_debounce_scheduler #(
    parameter int CLOCK_HZ           = 12_000_000,
    parameter int SCAN_HZ            = 100_000,
    parameter int NUM_KEYS           = 8,
    parameter int FILTER_COUNTER_MAX = 3,
    parameter int EVENT_FIFO_DEPTH   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         async_in,
    output logic [NUM_KEYS-1:0]         sync_out,
    output logic                        event_valid,
    input  logic                        event_ready,
    output logic [$clog2(NUM_KEYS)-1:0] event_key,
    output logic                        event_pressed,
    output logic                        overflow,
    input  logic                        clear_overflow,
    output logic                        scan_active_o
);

    localparam int DIV  = CLOCK_HZ / SCAN_HZ;
    localparam int KW   = $clog2(NUM_KEYS);
    localparam int CW   = $clog2(FILTER_COUNTER_MAX + 1);
    localparam int DIVW = $clog2(DIV);
    localparam int AW   = $clog2(EVENT_FIFO_DEPTH);
    localparam int EW   = KW + 1;

    if (DIV <= NUM_KEYS + 1) begin : g_div_check
        $error("shared_debounce_scheduler: DIV must exceed NUM_KEYS+1");
    end

    typedef enum logic {IDLE, SCAN} state_t;

    logic [NUM_KEYS-1:0] meta_q, sync_q, level_q;
    logic [DIVW-1:0]     div_q;
    state_t              state_q;
    logic [KW-1:0]       idx_q;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [EW-1:0]       mem_q [EVENT_FIFO_DEPTH];
    logic [AW:0]         wr_q, rd_q;
    logic                ovf_q;

    logic          tick, visit, cur_s, cur_lvl, flip;
    logic [CW:0]   cnt_inc;
    logic          fifo_empty, fifo_full, pop, push_ok, drop;

    always_comb begin
        tick    = (div_q == DIVW'(DIV - 1));
        visit   = (state_q == SCAN);
        cur_s   = sync_q[idx_q];
        cur_lvl = level_q[idx_q];
        cnt_inc = {1'b0, cnt_q[idx_q]} + 1'b1;
        flip    = visit && (cur_s != cur_lvl) && (cnt_inc == (CW+1)'(FILTER_COUNTER_MAX));
    end

    // Stream: an event transfers in any cycle with event_valid && event_ready;
    // the head stays put otherwise. A push into a full queue survives only if
    // the head leaves in that same cycle, else it is dropped and flagged.
    always_comb begin
        fifo_empty = (wr_q == rd_q);
        fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop        = !fifo_empty && event_ready;
        push_ok    = flip && (!fifo_full || pop);
        drop       = flip && fifo_full && !pop;
    end

    assign sync_out      = level_q;
    assign event_valid   = !fifo_empty;
    assign {event_key, event_pressed} = fifo_empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign overflow      = ovf_q;
    assign scan_active_o = (state_q == SCAN);

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q   <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end
                end
                SCAN: begin
                    if (idx_q == KW'(NUM_KEYS - 1)) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q  <= '0;
            sync_q  <= '0;
            level_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
            for (int j = 0; j < EVENT_FIFO_DEPTH; j++) mem_q[j] <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            if (visit) begin
                if (cur_s == cur_lvl) begin
                    cnt_q[idx_q] <= '0;
                end else if (flip) begin
                    level_q[idx_q] <= cur_s;
                    cnt_q[idx_q]   <= '0;
                end else begin
                    cnt_q[idx_q] <= cnt_inc[CW-1:0];
                end
            end
            if (push_ok) begin
                mem_q[wr_q[AW-1:0]] <= {idx_q, cur_s};
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            // A drop in the same cycle as a clear leaves the flag set.
            ovf_q <= drop | (ovf_q & ~clear_overflow);
        end
    end

endmodule

// File: tb/tb_shared_debounce_scheduler.sv
// Bench for shared_debounce_scheduler: directed phase table, random bouncing keys
// with random backpressure, and a mid-sweep reset, all tracked by a cycle model.
module tb_shared_debounce_scheduler;

    localparam int NK    = 8;
    localparam int DIV   = 120;
    localparam int FCM   = 3;
    localparam int DEPTH = 4;
    localparam int KW    = 3;

    logic          clock, reset;
    logic [NK-1:0] async_in, sync_out;
    logic          event_valid, event_ready;
    logic [KW-1:0] event_key;
    logic          event_pressed, overflow, clear_overflow, scan_active_o;

    int checks   = 0;
    int failures = 0;

    shared_debounce_scheduler #(
        .CLOCK_HZ(12_000_000), .SCAN_HZ(100_000), .NUM_KEYS(NK),
        .FILTER_COUNTER_MAX(FCM), .EVENT_FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .async_in(async_in), .sync_out(sync_out),
        .event_valid(event_valid), .event_ready(event_ready), .event_key(event_key),
        .event_pressed(event_pressed), .overflow(overflow),
        .clear_overflow(clear_overflow), .scan_active_o(scan_active_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: cycle number since reset, two-cycle delayed input view,
    // per-key run length of disagreeing samples, and the expected event queue.
    int            m_cycle;
    bit            m_init = 0;
    logic [NK-1:0] m_sync, m_p1, m_p2;
    int            m_run [NK];
    logic [KW:0]   exp_q [$];
    logic          m_ovf;

    int pop_cnt, rise2, first_scan, valid_seen;

    function automatic void model_reset();
        m_cycle = 0;
        m_sync  = '0;
        m_p1    = '0;
        m_p2    = '0;
        m_ovf   = 1'b0;
        for (int i = 0; i < NK; i++) m_run[i] = 0;
        exp_q.delete();
    endfunction

    function automatic void model_edge(input logic [NK-1:0] in_v, input logic rdy,
                                       input logic clr, input logic rst);
        bit          have_ev;
        logic [KW:0] ev;
        bit          dropped;
        int          k;
        if (rst) begin
            model_reset();
            return;
        end
        have_ev = 0;
        ev      = '0;
        dropped = 0;
        k       = m_cycle % DIV;
        if (m_cycle >= DIV && k < NK) begin
            if (m_p2[k] == m_sync[k]) begin
                m_run[k] = 0;
            end else begin
                m_run[k] = m_run[k] + 1;
                if (m_run[k] == FCM) begin
                    m_sync[k] = m_p2[k];
                    m_run[k]  = 0;
                    have_ev   = 1;
                    ev        = {KW'(k), m_p2[k]};
                end
            end
        end
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (have_ev) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ev);
            else dropped = 1;
        end
        m_ovf   = dropped ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_p2    = m_p1;
        m_p1    = in_v;
        m_cycle = m_cycle + 1;
    endfunction

    task automatic check_cycle();
        logic        e_valid, e_scan;
        logic [KW:0] e_head;
        e_valid = (exp_q.size() > 0);
        e_head  = e_valid ? exp_q[0] : '0;
        e_scan  = (m_cycle >= DIV) && ((m_cycle % DIV) < NK);
        checks++;
        if (sync_out !== m_sync || event_valid !== e_valid ||
            {event_key, event_pressed} !== e_head || overflow !== m_ovf ||
            scan_active_o !== e_scan) begin
            failures++;
            $display("FAIL cycle %0d: got sync=%h valid=%b key=%0d pr=%b ovf=%b scan=%b, need sync=%h valid=%b key=%0d pr=%b ovf=%b scan=%b",
                     m_cycle, sync_out, event_valid, event_key, event_pressed, overflow,
                     scan_active_o, m_sync, e_valid, e_head[KW:1], e_head[0], m_ovf, e_scan);
        end
        if (rise2 < 0 && sync_out[2] === 1'b1) rise2 = m_cycle;
        if (first_scan < 0 && scan_active_o === 1'b1) first_scan = m_cycle;
        if (event_valid === 1'b1) valid_seen++;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] need);
        checks++;
        if (got !== need) begin
            failures++;
            $display("FAIL %s: got %0d need %0d", name, got, need);
        end
    endtask

    logic [NK-1:0] last_in;

    task automatic cycle(input logic [NK-1:0] in_v, input logic rdy, input logic clr,
                         input logic rst);
        async_in       = in_v;
        event_ready    = rdy;
        clear_overflow = clr;
        reset          = rst;
        last_in        = in_v;
        @(negedge clock);
        if (m_init) check_cycle();
        if (event_valid === 1'b1 && rdy) pop_cnt++;
        @(posedge clock);
        model_edge(in_v, rdy, clr, rst);
        #1;
    endtask

    typedef struct {
        logic [NK-1:0] in_v;
        logic          rdy;
        logic          clr;
        int            cycles;
        logic [NK-1:0] exp_sync;
        logic          exp_ovf;
        int            exp_pops;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int guard;
        logic [NK-1:0] snap;
        reset          = 1'b1;
        async_in       = '0;
        event_ready    = 1'b0;
        clear_overflow = 1'b0;
        rise2          = -1;
        first_scan     = -1;
        valid_seen     = 0;
        pop_cnt        = 0;
        last_in        = '0;

        vecs[0]  = '{8'h00, 1'b1, 1'b0,  10, 8'h00, 1'b0, 0};
        vecs[1]  = '{8'h04, 1'b1, 1'b0, 400, 8'h04, 1'b0, 1};
        vecs[2]  = '{8'h24, 1'b1, 1'b0, 240, 8'h04, 1'b0, 0};
        vecs[3]  = '{8'h04, 1'b1, 1'b0, 360, 8'h04, 1'b0, 0};
        vecs[4]  = '{8'h24, 1'b1, 1'b0, 360, 8'h24, 1'b0, 1};
        vecs[5]  = '{8'h04, 1'b1, 1'b0, 400, 8'h04, 1'b0, 1};
        vecs[6]  = '{8'h00, 1'b1, 1'b0, 400, 8'h00, 1'b0, 1};
        vecs[7]  = '{8'h5B, 1'b0, 1'b0, 400, 8'h5B, 1'b1, 0};
        vecs[8]  = '{8'h5B, 1'b1, 1'b0,  10, 8'h5B, 1'b1, 4};
        vecs[9]  = '{8'h5B, 1'b1, 1'b1,   1, 8'h5B, 1'b0, 0};
        vecs[10] = '{8'h00, 1'b0, 1'b0, 305, 8'h40, 1'b0, 0};
        vecs[11] = '{8'h00, 1'b1, 1'b0,   1, 8'h00, 1'b0, 1};
        vecs[12] = '{8'h00, 1'b0, 1'b0, 100, 8'h00, 1'b0, 0};
        vecs[13] = '{8'h00, 1'b1, 1'b0,  10, 8'h00, 1'b0, 4};
        vecs[14] = '{8'h5B, 1'b0, 1'b0, 249, 8'h1B, 1'b0, 0};
        vecs[15] = '{8'h5B, 1'b0, 1'b1,   1, 8'h5B, 1'b1, 0};
        vecs[16] = '{8'h5B, 1'b0, 1'b1,   1, 8'h5B, 1'b0, 0};
        vecs[17] = '{8'h5B, 1'b1, 1'b0,  10, 8'h5B, 1'b0, 4};

        @(posedge clock);
        model_reset();
        m_init = 1;
        #1;
        cycle('0, 1'b0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b0, 1'b1);
        check_val("reset_sync", 32'(sync_out), 0);
        check_val("reset_valid", 32'(event_valid), 0);
        check_val("reset_head", 32'({event_key, event_pressed}), 0);
        check_val("reset_ovf", 32'(overflow), 0);

        for (int v = 0; v < 18; v++) begin
            pop_cnt = 0;
            for (int k = 0; k < vecs[v].cycles; k++)
                cycle(vecs[v].in_v, vecs[v].rdy, vecs[v].clr, 1'b0);
            check_val($sformatf("vec%0d_sync", v), 32'(sync_out), 32'(vecs[v].exp_sync));
            check_val($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
            check_val($sformatf("vec%0d_pops", v), pop_cnt, vecs[v].exp_pops);
            if (v == 1) check_val("key2_rise_cycle", rise2, 363);
        end

        for (int r = 0; r < 40; r++) begin
            logic [NK-1:0] in_v;
            int hold;
            in_v = NK'($urandom);
            hold = $urandom_range(30, 450);
            for (int k = 0; k < hold; k++)
                cycle(in_v, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1'b0);
        end

        guard = 0;
        while ((m_cycle % DIV) != DIV - 10 && guard < 300) begin
            cycle(last_in, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        check_val("reset_align_idle", 32'(guard < 300), 1);
        snap  = ~m_sync;
        guard = 0;
        while ((m_cycle % DIV) != 4 && guard < 300) begin
            cycle(snap, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        check_val("reset_align_idx4", 32'(guard < 300), 1);
        check_val("reset_midsweep_scan", 32'(scan_active_o), 1);
        cycle('0, 1'b1, 1'b0, 1'b1);
        check_val("midreset_sync", 32'(sync_out), 0);
        check_val("midreset_valid", 32'(event_valid), 0);
        check_val("midreset_head", 32'({event_key, event_pressed}), 0);
        check_val("midreset_ovf", 32'(overflow), 0);
        check_val("midreset_scan", 32'(scan_active_o), 0);
        first_scan = -1;
        valid_seen = 0;
        for (int k = 0; k < 130; k++) cycle('0, 1'b1, 1'b0, 1'b0);
        check_val("post_reset_first_scan", first_scan, DIV);
        check_val("post_reset_no_event", valid_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
